instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Builds RV32I instruction words from field-level commands and streams them,
//  each with a byte address, to the instruction-memory loader.
//  Covers the instruction subset handled by the single-cycle control decoder:
//  add/sub/and/or/lw/sw/beq. Used by the program-load path and by test benches.
//  Contains a DEPTH-entry output FIFO and a wrapping address counter.
// PARAMETERS
//  DEPTH      4    output FIFO entries; must be a power of 2 and >= 2
//  ADDR_W     8    width of out_addr in bits; the counter wraps at 2^ADDR_W
//  BASE_ADDR  0    out_addr value after reset; must be a multiple of 4
// PORTS
//  clk        in   1       clock; all logic updates on the rising edge
//  rst        in   1       synchronous active-high reset
//  in_valid   in   1       command valid
//  in_ready   out  1       command accepted when in_valid & in_ready
//  in_op      in   3       0 add, 1 sub, 2 and, 3 or, 4 lw, 5 sw, 6 beq, 7 illegal
//  in_rd      in   5       destination register; ignored for sw and beq
//  in_rs1     in   5       source register 1
//  in_rs2     in   5       source register 2; ignored for lw
//  in_imm     in   13      lw/sw use [11:0] as signed; beq uses [12:0] as signed, [0] must be 0
//  out_valid  out  1       FIFO head valid
//  out_ready  in   1       loader takes the head when out_valid & out_ready
//  out_instr  out  32      encoded instruction word at the FIFO head
//  out_addr   out  ADDR_W  byte address for out_instr
//  err        out  1       one-cycle pulse on a rejected command
//  count      out  clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: FIFO is emptied; in_ready=1; out_valid=0; out_instr=0; err=0; count=0;
//   out_addr=BASE_ADDR. rst has priority over all other activity, and an
//   in-flight handshake in the reset cycle is discarded.
//  Encoding (standard RV32I):
//   R-type: {f7,rs2,rs1,f3,rd,7'b0110011}
//    add: f7=0,        f3=000
//    sub: f7=0100000,  f3=000
//    or:  f7=0,        f3=110
//    and: f7=0,        f3=111
//   lw:  {imm[11:0],rs1,3'b010,rd,7'b0000011}
//   sw:  {imm[11:5],rs2,rs1,3'b010,imm[4:0],7'b0100011}
//   beq: {imm[12],imm[10:5],rs2,rs1,3'b000,imm[4:1],imm[11],7'b1100011}
//  Input handshake: in_ready = (count < DEPTH). A pop in the same cycle does
//   not raise in_ready, so there is no full pass-through.
//  Latency: a command accepted in cycle N is encoded and pushed at edge N.
//   If the FIFO was empty, out_valid=1 with that word in cycle N+1.
//  FIFO: strictly in order. Push and pop in the same cycle leave count
//   unchanged. out_instr and out_addr hold stable while out_valid & !out_ready.
//  Address: out_addr is a registered counter. It advances by 4 on each output
//   handshake and wraps modulo 2^ADDR_W. A dropped command never advances it.
//  Errors: op=7, or beq with imm[0]=1, is a rejected command.
//   - The command is still accepted (in_ready is unchanged).
//   - err=1 for exactly the next cycle.
//   - Back-to-back rejects give err=1 on each following cycle.
//  Boundaries:
//   - count never exceeds DEPTH; out_valid=0 whenever count=0.
//   - lw/sw immediates outside [11:0] are truncated; in_imm[12] is ignored.
// CONFIGURATION
//  ENC_NOP_ON_ERR_EN
//   defined:   a rejected command pushes NOP 0x00000013 (addi x0,x0,0) and
//              consumes an address like any other word; err still pulses.
//   undefined: a rejected command is dropped; nothing is pushed.
// TESTING
//  1 add rd=3 rs1=1 rs2=2, out_ready=1 -> out_instr=0x002081B3, out_addr=0x00,
//    out_valid 1 cycle after accept.
//  2 sub 5,6,7 -> 0x407302B3; lw rd=1 rs1=2 imm=8 -> 0x00812083;
//    sw rs2=3 rs1=4 imm=12 -> 0x00322623; beq rs1=1 rs2=2 imm=-4 -> 0xFE208EE3.
//    Sent in that order: out_addr = 0x00, 0x04, 0x08, 0x0C.
//  3 out_ready=0, push 5 commands -> in_ready=0 after the 4th, count=4, the 5th
//    is held. Then out_ready=1 -> words drain in order, in_ready returns 1.
//  4 BASE_ADDR=0xF8, ADDR_W=8, send 3 words -> out_addr = 0xF8, 0xFC, 0x00.
//  5 op=7 -> err=1 for 1 cycle, count unchanged, next add gets the unchanged address.
//    With ENC_NOP_ON_ERR_EN: 0x00000013 is emitted at that address instead.
//  6 rst=1 with count=3 and a push pending -> next cycle count=0, out_valid=0,
//    out_addr=BASE_ADDR, err=0.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes RV32I add/sub/and/or/lw/sw/beq commands into an in-order output FIFO
// with a wrapping byte-address counter. Optional macro ENC_NOP_ON_ERR_EN: rejected commands emit a NOP.
module instr_encoder #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2:0]              in_op,
   input  logic [4:0]              in_rd,
   input  logic [4:0]              in_rs1,
   input  logic [4:0]              in_rs2,
   input  logic [12:0]             in_imm,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_instr,
   output logic [ADDR_W-1:0]       out_addr,
   output logic                    err,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_LW  = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_BEQ = 3'd6;

   localparam logic [6:0] OPC_R  = 7'b0110011;
   localparam logic [6:0] OPC_LD = 7'b0000011;
   localparam logic [6:0] OPC_ST = 7'b0100011;
   localparam logic [6:0] OPC_BR = 7'b1100011;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic [31:0]   enc;
   logic          bad;
   logic          accept;
   logic          push;
   logic          pop;
   logic [31:0]   wdata;
   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Field-level encoder; anything it cannot express is flagged bad.
   always_comb begin
      enc = 32'h0;
      bad = 1'b0;
      case (in_op)
         OP_ADD: enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
         OP_SUB: enc = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
         OP_AND: enc = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OPC_R};
         OP_OR:  enc = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OPC_R};
         OP_LW:  enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LD};
         OP_SW:  enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_ST};
         OP_BEQ: begin
            enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                   in_imm[4:1], in_imm[11], OPC_BR};
            bad = in_imm[0];
         end
         default: bad = 1'b1;
      endcase
   end

   assign in_ready  = (count < FULL);
   assign out_valid = (count != '0);
   assign accept    = in_valid & in_ready & ~rst;
   assign pop       = out_valid & out_ready & ~rst;

`ifdef ENC_NOP_ON_ERR_EN
   assign push  = accept;
   assign wdata = bad ? NOP : enc;
`else
   assign push  = accept & ~bad;
   assign wdata = enc;
`endif

   // Address belongs to the head slot, so it only moves on an output handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         err      <= 1'b0;
         out_addr <= ADDR_W'(BASE_ADDR);
      end else begin
         err <= accept & bad;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + PW'(1);
            out_addr <= out_addr + ADDR_W'(4);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wdata;
   end

   assign out_instr = out_valid ? mem[rd_ptr] : 32'h0;

endmodule
